// File: rtl/my_mul_if.sv
// Handshake and operand/result bundle for the sequential signed multiply-accumulate unit.
interface my_mul_if #(
    parameter int unsigned aBITS = 20,
    parameter int unsigned bBITS = 10,
    parameter int unsigned cBITS = aBITS + bBITS - 1
);
    localparam int unsigned pBITS = aBITS + bBITS;

    logic                    start;
    logic signed [aBITS-1:0] a;
    logic signed [bBITS-1:0] b;
    logic signed [cBITS-1:0] c;
    logic                    busy;
    logic                    done;
    logic signed [pBITS-1:0] product;

    modport master (output start, a, b, c, input busy, done, product);
    modport slave  (input start, a, b, c, output busy, done, product);
endinterface

// File: rtl/my_mul.sv
// Iterative radix-2 signed multiply-accumulate: product = a*b + c, one bit of |a| per clock.
module my_mul #(
    parameter int unsigned aBITS = 20,
    parameter int unsigned bBITS = 10,
    parameter int unsigned cBITS = aBITS + bBITS - 1
) (
    input  logic     clk,
    input  logic     rst,
    my_mul_if.slave  bus
);
    localparam int unsigned pBITS = aBITS + bBITS;
    localparam int unsigned CNT_W = $clog2(aBITS + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t                  state_q, state_d;
    logic [aBITS-1:0]        a_mag_q, a_mag_d;
    logic [bBITS-1:0]        b_mag_q, b_mag_d;
    logic                    sign_q, sign_d;
    logic signed [cBITS-1:0] c_q, c_d;
    logic [pBITS-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [pBITS-1:0] product_q, product_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            sign_q    <= 1'b0;
            c_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            sign_q    <= sign_d;
            c_q       <= c_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        sign_d    = sign_q;
        c_d       = c_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Magnitudes held unsigned so the most-negative input is exact.
                    a_mag_d = aBITS'(bus.a[aBITS-1] ? -bus.a : bus.a);
                    b_mag_d = bBITS'(bus.b[bBITS-1] ? -bus.b : bus.b);
                    sign_d  = bus.a[aBITS-1] ^ bus.b[bBITS-1];
                    c_d     = bus.c;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (a_mag_q[0]) begin
                    acc_d = acc_q + (pBITS'(b_mag_q) << cnt_q);
                end
                a_mag_d = a_mag_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(aBITS - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                product_d = (sign_q ? -acc_q : acc_q) + pBITS'(c_q);
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_my_mul.sv
// Self-checking bench for my_mul: vector table, handshake corner cases and divider round-trip.
module tb_my_mul;
    localparam int unsigned A_W = 20;
    localparam int unsigned B_W = 10;
    localparam int unsigned C_W = 29;
    localparam int unsigned P_W = 30;
    localparam int          LAT = 21;

    typedef logic signed [P_W-1:0] prod_t;
    typedef struct {
        logic signed [A_W-1:0] a;
        logic signed [B_W-1:0] b;
        logic signed [C_W-1:0] c;
        prod_t                 exp;
    } vec_t;

    logic clk;
    logic rst;

    my_mul_if #(.aBITS(A_W), .bBITS(B_W), .cBITS(C_W)) bus ();
    my_mul    #(.aBITS(A_W), .bBITS(B_W), .cBITS(C_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t  vecs [10];
    prod_t sb [$];
    int    checks = 0;
    int    errors = 0;

    function automatic vec_t mk(input longint a, input longint b, input longint c, input longint e);
        vec_t v;
        v.a   = A_W'(a);
        v.b   = B_W'(b);
        v.c   = C_W'(c);
        v.exp = P_W'(e);
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pops the oldest pending expectation.
    always @(negedge clk) begin
        prod_t e;
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1, expected no pending result (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("product", bus.product, e);
                chk("busy_with_done", longint'(bus.busy), 0);
            end
        end
    end

    task automatic issue(input vec_t v, input bit push);
        bus.start = 1'b1;
        bus.a     = v.a;
        bus.b     = v.b;
        bus.c     = v.c;
        if (push) sb.push_back(v.exp);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = A_W'($urandom);
        bus.b     = B_W'($urandom);
        bus.c     = C_W'($urandom);
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int lat;
        int bcnt;
        lat  = 0;
        bcnt = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done within %0d cycles, expected done after %0d", name, lat, exp_lat);
        end else begin
            chk({name, "_latency"}, lat, exp_lat);
            chk({name, "_busy_cycles"}, bcnt, exp_lat);
        end
    endtask

    task automatic run_op(input vec_t v, input string name);
        issue(v, 1'b1);
        wait_done(name, LAT);
        @(negedge clk);
        chk({name, "_done_pulse"}, longint'(bus.done), 0);
        chk({name, "_hold"}, bus.product, v.exp);
    endtask

    initial begin
        int ndone;
        vec_t v;
        longint bv, lim, d;

        vecs[0] = mk(1234, 56, 0, 69104);
        vecs[1] = mk(-5, 7, 3, -32);
        vecs[2] = mk(-5, -7, -3, 32);
        vecs[3] = mk(5, -7, 3, -32);
        vecs[4] = mk(5, 7, -3, 32);
        vecs[5] = mk(-524288, -512, 0, 268435456);
        vecs[6] = mk(524287, 511, 268435455, 536346112);
        vecs[7] = mk(0, -512, -268435456, -268435456);
        vecs[8] = mk(-524288, 511, 0, -267911168);
        vecs[9] = mk(524287, -512, -1, -268434945);

        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.c = '0;
        #3;
        chk("reset_busy", longint'(bus.busy), 0);
        chk("reset_done", longint'(bus.done), 0);
        chk("reset_product", bus.product, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_op(vecs[i], "vec");

        // start pulsed mid-operation must be ignored
        issue(vecs[1], 1'b1);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.a = A_W'(777);
        bus.b = B_W'(-3);
        bus.c = C_W'(11);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("busy_start", LAT - 5);
        @(negedge clk);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done) ndone++;
            @(negedge clk);
        end
        chk("busy_start_extra_done", ndone, 0);

        // start accepted in the done cycle
        issue(vecs[0], 1'b1);
        wait_done("b2b_first", LAT);
        issue(vecs[6], 1'b1);
        chk("b2b_done_drop", longint'(bus.done), 0);
        chk("b2b_busy", longint'(bus.busy), 1);
        wait_done("b2b_second", LAT);
        @(negedge clk);

        // asynchronous reset mid-operation discards the partial result
        issue(vecs[2], 1'b0);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", longint'(bus.busy), 0);
        chk("async_rst_done", longint'(bus.done), 0);
        chk("async_rst_product", bus.product, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("rst_no_done", ndone, 0);
        run_op(vecs[3], "after_rst");

        // divider round-trip: quotient*divisor + remainder rebuilds the dividend
        for (int i = 0; i < 1000; i++) begin
            bv = longint'($urandom_range(0, 1023)) - 512;
            if (bv == 0) bv = 1;
            lim = ((longint'(1) <<< 19) - 1) * ((bv < 0) ? -bv : bv);
            d = longint'($urandom_range(0, 32'(2 * lim))) - lim;
            v = mk(d / bv, bv, d % bv, d);
            run_op(v, "roundtrip");
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
